param_delay_counter: RTL

- Parametrised successor of the fixed-delay click counter: a prescaler divides clk by a programmable period and each prescaler terminal advances a programmable-modulus step counter.
- Adds up/down direction, free-run/one-shot modes, enable/pause, runtime reload, and tick/wrap/done status.
- Drives display/LED sequencing and timed events in the lab designs.

---
 rtl/param_delay_counter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/param_delay_counter.sv
// ---------------------------------------------------------------------------
// param_delay_counter
//
// Programmable prescaler followed by a programmable-modulus step counter.
// The prescaler divides clk by (prescale_reg + 1). Each time the prescaler
// reaches its terminal value, the step counter advances once, either up or
// down. In free-run mode the counter wraps. In one-shot mode it stops at its
// terminal value and raises a sticky done flag.
//
// Parameters:
//   PRESCALE_W   width of the prescaler and of the prescale period register
//   COUNT_W      width of the step counter and of the top register
//   DEFAULT_TOP  top value loaded at reset (must fit in COUNT_W bits)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   enable       1 = run, 0 = freeze the prescaler, counter and done
//   load         synchronous reload strobe (has priority over enable)
//   prescale_in  new prescale terminal value; period = prescale_in + 1
//   top_in       new counter top; modulus = top_in + 1
//   dir          0 = count up, 1 = count down (sampled on each step)
//   one_shot     0 = free-run with wrap, 1 = stop at terminal
//   count        current step counter value
//   tick         one-cycle pulse in the cycle after a step edge
//   wrap         one-cycle pulse on a step that wraps
//   done         sticky flag: the one-shot terminal has been reached
// ---------------------------------------------------------------------------
module param_delay_counter #(
    parameter int PRESCALE_W  = 22,
    parameter int COUNT_W     = 4,
    parameter int DEFAULT_TOP = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] prescale_in,
    input  logic [COUNT_W-1:0]    top_in,
    input  logic                  dir,
    input  logic                  one_shot,
    output logic [COUNT_W-1:0]    count,
    output logic                  tick,
    output logic                  wrap,
    output logic                  done
);

    localparam logic [COUNT_W-1:0] TOP_INIT = COUNT_W'(DEFAULT_TOP);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic [COUNT_W-1:0]    top_reg;

    logic [COUNT_W-1:0]    terminal_val;
    logic [COUNT_W-1:0]    start_val;
    logic [COUNT_W-1:0]    advanced_val;
    logic                  prescale_hit;
    logic                  at_terminal;
    logic                  next_is_terminal;

    // The terminal and start values swap roles with the direction. The
    // direction is sampled live, so a mid-run change continues from the
    // current count toward the new terminal.
    always_comb begin
        terminal_val     = dir ? '0 : top_reg;
        start_val        = dir ? top_reg : '0;
        advanced_val     = dir ? (count - COUNT_W'(1)) : (count + COUNT_W'(1));
        prescale_hit     = (pre_cnt == prescale_reg);
        at_terminal      = (count == terminal_val);
        next_is_terminal = (advanced_val == terminal_val);
    end

    // All state and status outputs are registered here. Each edge resolves
    // in the order load, then freeze, then normal run. tick and wrap are
    // pulses, so they are cleared on every edge that does not set them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt      <= '0;
            prescale_reg <= '1;
            top_reg      <= TOP_INIT;
            count        <= '0;
            tick         <= 1'b0;
            wrap         <= 1'b0;
            done         <= 1'b0;
        end else if (load) begin
            prescale_reg <= prescale_in;
            top_reg      <= top_in;
            pre_cnt      <= '0;
            done         <= 1'b0;
            tick         <= 1'b0;
            wrap         <= 1'b0;
            count        <= dir ? top_in : '0;
        end else if (!enable) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (!prescale_hit) begin
                pre_cnt <= pre_cnt + PRESCALE_W'(1);
            end else begin
                pre_cnt <= '0;
                // Once done is set, steps are swallowed until the next
                // load, even if one_shot has since been cleared.
                if (!done) begin
                    tick <= 1'b1;
                    if (!one_shot) begin
                        if (at_terminal) begin
                            count <= start_val;
                            wrap  <= 1'b1;
                        end else begin
                            count <= advanced_val;
                        end
                    end else begin
                        // A one-shot step that lands on the terminal sets
                        // done on that same edge. A step taken while
                        // already parked on the terminal also sets done.
                        if (at_terminal) begin
                            done <= 1'b1;
                        end else begin
                            count <= advanced_val;
                            if (next_is_terminal) begin
                                done <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

endmodule
